// File: rtl/gpu_port_pkg.sv
// Shared constants for the CPU-side video-memory port: register offsets,
// status bit positions and the fill engine state encoding.
package gpu_port_pkg;

    localparam logic [2:0] REG_ADDR   = 3'd0;
    localparam logic [2:0] REG_BANKR  = 3'd1;
    localparam logic [2:0] REG_BANKW  = 3'd2;
    localparam logic [2:0] REG_DATA   = 3'd3;
    localparam logic [2:0] REG_STEP   = 3'd4;
    localparam logic [2:0] REG_FILL   = 3'd5;
    localparam logic [2:0] REG_COUNT  = 3'd6;
    localparam logic [2:0] REG_STATUS = 3'd7;

    localparam int ST_BUSY = 0;
    localparam int ST_FULL = 1;
    localparam int ST_OVF  = 2;

    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILL_RUN  = 1'b1
    } fill_state_t;

endpackage

// File: rtl/gpu_port_if.sv
// CPU bus plus video-memory write port of gpu_port_ctrl; the controller
// takes the slave side, the CPU/memory environment the master side.
interface gpu_port_if #(
    parameter int AW = 16,
    parameter int BW = 1
);
    logic [15:0]      cpu_address;
    logic             cpu_we;
    logic [7:0]       cpu_data;
    logic             sel;
    logic [7:0]       status;
    logic [BW-1:0]    bank_r;
    logic [BW+AW-1:0] vm_address;
    logic [7:0]       vm_data;
    logic             vm_we;
    logic             vm_ready;

    modport master (
        output cpu_address, cpu_we, cpu_data, vm_ready,
        input  sel, status, bank_r, vm_address, vm_data, vm_we
    );

    modport slave (
        input  cpu_address, cpu_we, cpu_data, vm_ready,
        output sel, status, bank_r, vm_address, vm_data, vm_we
    );
endinterface

// File: rtl/gpu_port_fifo.sv
// Synchronous write FIFO with a combinational head; simultaneous push and
// pop are both honoured. Callers must not push when full or pop when empty.
module gpu_port_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr, rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign rdata = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/gpu_port_ctrl.sv
// CPU-side video-memory port: register window at BASE, write FIFO toward
// the memory port and, when GPU_PORT_FILL_EN is defined, a block-fill engine.
module gpu_port_ctrl
    import gpu_port_pkg::*;
#(
    parameter logic [15:0] BASE  = 16'h20,
    parameter int          AW    = 16,
    parameter int          BANKS = 2,
    parameter int          DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    gpu_port_if.slave  bus
);
    localparam int BW = $clog2(BANKS);
    localparam int FW = BW + AW + 8;

    logic [15:0]    rel;
    logic [2:0]     off;
    logic           wr;
    logic [AW-1:0]  addr, step, count;
    logic [AW+7:0]  addr_cat, count_cat;
    logic [BW-1:0]  bank_r, bank_w;
    logic           ovf;
    logic           fill_busy, fill_push, data_push, data_drop;
    logic           push, pop, full, empty;
    logic [7:0]     push_byte;
    logic [FW-1:0]  wdata, rdata;
    logic [7:0]     status_q, status_d;
    logic           vm_we_q;
    logic [BW+AW-1:0] vm_address_q;
    logic [7:0]     vm_data_q;

    // Unsigned offset compare also rejects addresses below BASE via wrap.
    assign rel      = bus.cpu_address - BASE;
    assign off      = rel[2:0];
    assign bus.sel  = (rel < 16'd8);
    assign wr       = bus.cpu_we && bus.sel;

    assign addr_cat  = {addr, bus.cpu_data};
    assign count_cat = {count, bus.cpu_data};

    assign data_push = wr && (off == REG_DATA) && !full && !fill_busy;
    assign data_drop = wr && (off == REG_DATA) && (full || fill_busy);
    assign push      = data_push || fill_push;
    assign pop       = !empty && bus.vm_ready;
    assign wdata     = {bank_w, addr, push_byte};

`ifdef GPU_PORT_FILL_EN
    fill_state_t   state_q, state_d;
    logic [AW-1:0] remain;
    logic [7:0]    fval;
    logic          fill_start;

    assign fill_busy = (state_q == FILL_RUN);
    assign fill_push = fill_busy && !full;
    assign push_byte = fill_push ? fval : bus.cpu_data;

    always_comb begin
        state_d    = state_q;
        fill_start = 1'b0;
        case (state_q)
            FILL_IDLE: if (wr && (off == REG_FILL) && (count != '0)) begin
                state_d    = FILL_RUN;
                fill_start = 1'b1;
            end
            FILL_RUN: if (fill_push && (remain == AW'(1))) state_d = FILL_IDLE;
            default: state_d = FILL_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FILL_IDLE;
            remain  <= '0;
            fval    <= '0;
            count   <= '0;
        end else begin
            state_q <= state_d;
            if (fill_start) begin
                remain <= count;
                fval   <= bus.cpu_data;
            end else if (fill_push) begin
                remain <= remain - 1'b1;
            end
            if (wr && (off == REG_COUNT) && !fill_busy) count <= count_cat[AW-1:0];
        end
    end
`else
    assign fill_busy = 1'b0;
    assign fill_push = 1'b0;
    assign push_byte = bus.cpu_data;
    assign count     = '0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr   <= '0;
            step   <= AW'(1);
            bank_r <= '0;
            bank_w <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) addr <= addr + step;
            else if (wr && (off == REG_ADDR) && !fill_busy) addr <= addr_cat[AW-1:0];
            if (wr && (off == REG_BANKR)) bank_r <= bus.cpu_data[BW-1:0];
            if (wr && (off == REG_BANKW)) bank_w <= bus.cpu_data[BW-1:0];
            if (wr && (off == REG_STEP))  step   <= AW'(bus.cpu_data);
            if (data_drop) ovf <= 1'b1;
            else if (wr && (off == REG_STATUS) && bus.cpu_data[2]) ovf <= 1'b0;
        end
    end

    gpu_port_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        status_d          = '0;
        status_d[ST_BUSY] = fill_busy || !empty;
        status_d[ST_FULL] = full;
        status_d[ST_OVF]  = ovf;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            status_q     <= '0;
            vm_we_q      <= 1'b0;
            vm_address_q <= '0;
            vm_data_q    <= '0;
        end else begin
            status_q <= status_d;
            vm_we_q  <= pop;
            if (pop) begin
                vm_address_q <= rdata[FW-1:8];
                vm_data_q    <= rdata[7:0];
            end
        end
    end

    assign bus.status     = status_q;
    assign bus.bank_r     = bank_r;
    assign bus.vm_we      = vm_we_q;
    assign bus.vm_address = vm_address_q;
    assign bus.vm_data    = vm_data_q;

endmodule
